// File: rtl/lcd_pkg.sv
// Shared constants for the 4-bit HD44780 write sequencer: FSM state codes,
// strobe phases, the init nibble/wait tables and the configuration byte ROM.
package lcd_pkg;

  localparam logic [3:0] S_PWRON     = 4'd0;
  localparam logic [3:0] S_INIT_NIB  = 4'd1;
  localparam logic [3:0] S_INIT_WAIT = 4'd2;
  localparam logic [3:0] S_CFG       = 4'd3;
  localparam logic [3:0] S_IDLE      = 4'd4;
  localparam logic [3:0] S_HI_NIB    = 4'd5;
  localparam logic [3:0] S_GAP       = 4'd6;
  localparam logic [3:0] S_LO_NIB    = 4'd7;
  localparam logic [3:0] S_POST_WAIT = 4'd8;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_PULSE = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  localparam logic [7:0] CFG_FUNC_SET   = 8'h28;
  localparam logic [7:0] CFG_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CFG_DISP_ON    = 8'h0C;
  localparam logic [7:0] CFG_CLEAR      = 8'h01;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Three wake-up nibbles, then the switch to 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
  endfunction

  function automatic int init_wait(input logic [1:0] idx, input int t1,
                                   input int t2, input int tc);
    case (idx)
      2'd0:    return t1;
      2'd1:    return t2;
      default: return tc;
    endcase
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_FUNC_SET;
      2'd1:    return CFG_ENTRY_MODE;
      2'd2:    return CFG_DISP_ON;
      default: return CFG_CLEAR;
    endcase
  endfunction

  // Clear and home need the long execution wait; everything else is short.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLEAR) || (data == OP_HOME));
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One enable-strobed nibble transfer: T_SETUP cycles setup, T_PULSE cycles
// with e high, one hold cycle. d is cleared afterwards, rs is kept.
module lcd_nibble_strobe
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] nibble_i,
  input  logic       rs_i,
  output logic [3:0] d_o,
  output logic       rs_o,
  output logic       e_o,
  output logic       done_o
);

  localparam int SW = $clog2(max_int(T_SETUP, T_PULSE) + 1);

  logic [1:0]    phase_q, phase_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    d_q, d_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rs_d    = rs_q;
    e_d     = e_q;
    case (phase_q)
      PH_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = PH_PULSE;
          cnt_d   = SW'(T_PULSE - 1);
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      PH_PULSE: begin
        if (cnt_q == '0) begin
          phase_d = PH_HOLD;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      PH_HOLD: begin
        phase_d = PH_IDLE;
        d_d     = 4'h0;
      end
      default: ;
    endcase
    if (start_i) begin
      phase_d = PH_SETUP;
      cnt_d   = SW'(T_SETUP - 1);
      d_d     = nibble_i;
      rs_d    = rs_i;
      e_d     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      d_q     <= 4'h0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
    end
  end

  assign d_o    = d_q;
  assign rs_o   = rs_q;
  assign e_o    = e_q;
  assign done_o = (phase_q == PH_HOLD);

endmodule

// File: rtl/lcd_write_sequencer.sv
// Character LCD writer in 4-bit mode: power-on init, configuration, then
// upstream byte writes. Define LCD_INIT_EN to build the init/config sequence.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int T_PWRON  = 750000,
  parameter int T_INIT1  = 205000,
  parameter int T_INIT2  = 5000,
  parameter int T_CMD    = 2000,
  parameter int T_CLR    = 82000,
  parameter int T_SETUP  = 2,
  parameter int T_PULSE  = 12,
  parameter int T_NIBGAP = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [3:0] d,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic       sf_e
);

  localparam int T_MAX = max_int(max_int(max_int(T_PWRON, T_INIT1),
                                         max_int(T_INIT2, T_CMD)),
                                 max_int(T_CLR, T_NIBGAP));
  localparam int CNT_W = $clog2(T_MAX);

`ifdef LCD_INIT_EN
  localparam logic [3:0] RESET_STATE = S_PWRON;
`else
  localparam logic [3:0] RESET_STATE = S_IDLE;
`endif

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             init_done_q, init_done_d;
  logic             ready_q, ready_d;

  logic             strb_start;
  logic [3:0]       strb_nib;
  logic             strb_rs;
  logic             strb_done;

  assign cnt_dec = cnt_q - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
`ifdef LCD_INIT_EN
    init_done_d = init_done_q;
`else
    init_done_d = 1'b1;
`endif
    strb_start  = 1'b0;
    strb_nib    = 4'h0;
    strb_rs     = 1'b0;
    case (state_q)
      S_PWRON: begin
        if (cnt_q == '0) begin
          state_d    = S_INIT_NIB;
          strb_start = 1'b1;
          strb_nib   = init_nibble(idx_q);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_INIT_NIB: begin
        if (strb_done) begin
          state_d = S_INIT_WAIT;
          cnt_d   = CNT_W'(init_wait(idx_q, T_INIT1, T_INIT2, T_CMD) - 1);
        end
      end
      S_INIT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else if (idx_q == 2'd3) begin
          state_d = S_CFG;
          idx_d   = 2'd0;
        end else begin
          state_d    = S_INIT_NIB;
          idx_d      = idx_q + 2'd1;
          strb_start = 1'b1;
          strb_nib   = init_nibble(idx_q + 2'd1);
        end
      end
      S_CFG: begin
        state_d    = S_HI_NIB;
        data_d     = cfg_byte(idx_q);
        rs_d       = 1'b0;
        strb_start = 1'b1;
        strb_nib   = cfg_byte(idx_q) >> 4;
      end
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d    = S_HI_NIB;
          data_d     = req_data;
          rs_d       = req_rs;
          strb_start = 1'b1;
          strb_nib   = req_data[7:4];
          strb_rs    = req_rs;
        end
      end
      S_HI_NIB: begin
        if (strb_done) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(T_NIBGAP - 1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d    = S_LO_NIB;
          strb_start = 1'b1;
          strb_nib   = data_q[3:0];
          strb_rs    = rs_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_LO_NIB: begin
        if (strb_done) begin
          state_d = S_POST_WAIT;
          cnt_d   = is_slow_cmd(rs_q, data_q) ? CNT_W'(T_CLR - 1)
                                              : CNT_W'(T_CMD - 1);
        end
      end
      S_POST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else if (init_done_q) begin
          state_d = S_IDLE;
        end else if (idx_q == 2'd3) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = S_CFG;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Ready is registered: it asserts in the first IDLE cycle and drops the
  // cycle after an accept.
  assign ready_d = (state_d == S_IDLE) && init_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      cnt_q       <= CNT_W'(T_PWRON - 1);
      idx_q       <= 2'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
    end
  end

  lcd_nibble_strobe #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .start_i  (strb_start),
    .nibble_i (strb_nib),
    .rs_i     (strb_rs),
    .d_o      (d),
    .rs_o     (rs),
    .e_o      (e),
    .done_o   (strb_done)
  );

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign rw        = 1'b0;
  assign sf_e      = 1'b1;

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
Drives the board's character LCD in 4-bit mode, with no read-back.
- Runs the LCD power-on init and configuration sequence itself.
- Then accepts byte writes (command or character) from upstream logic, e.g. the multiplier result formatter, over a valid/ready handshake.
- Splits each byte into two enable-strobed nibble transfers and enforces all HD44780 setup, pulse, gap and execution delays.
- Sits between result/format logic and the LCD pins (d, rs, rw, e, sf_e).

Parameters:
- T_PWRON, 750000, power-on wait cycles (15 ms @ 50 MHz)
- T_INIT1, 205000, wait after first 0x3 init nibble (4.1 ms)
- T_INIT2, 5000, wait after second 0x3 init nibble (100 us)
- T_CMD, 2000, post-byte execution wait for normal commands/data (40 us)
- T_CLR, 82000, post-byte wait for clear/home commands (1.64 ms)
- T_SETUP, 2, cycles d/rs stable before e rises
- T_PULSE, 12, cycles e held high
- T_NIBGAP, 50, cycles between upper and lower nibble (1 us)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  upstream byte write request
- req_rs  in  1  0 = command, 1 = character data
- req_data  in  8  byte to write
- req_ready  out  1  sequencer can accept a byte this cycle
- init_done  out  1  init/config complete; sticky until rst
- d  out  4  LCD data nibble (SF_D[11:8])
- rs  out  1  LCD register select
- rw  out  1  LCD read/write; tied 0
- e  out  1  LCD enable strobe
- sf_e  out  1  StrataFlash disable; tied 1

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: d=0, rs=0, e=0, req_ready=0, init_done=0, rw=0, sf_e=1. All counters and FSM return to PWRON.
- Reset asserted mid-transfer: e is 0 the cycle after the reset edge, and the full init sequence restarts.
- Nibble transfer (shared by all paths):
  - T_SETUP cycles with d/rs driven and e=0.
  - T_PULSE cycles with e=1.
  - 1 hold cycle with e=0 and d/rs unchanged.
- FSM states: PWRON, INIT_NIB, INIT_WAIT, CFG, IDLE, HI_NIB, GAP, LO_NIB, POST_WAIT.
- Init sequence:
  - PWRON: wait T_PWRON cycles.
  - INIT_NIB/INIT_WAIT: nibbles 0x3, 0x3, 0x3, 0x2 with rs=0. Waits after each are T_INIT1, T_INIT2, T_CMD, T_CMD.
  - CFG: bytes 0x28, 0x06, 0x0C, 0x01 (rs=0), each through the full byte path below. Byte source is an internal 4-entry ROM.
  - After the last POST_WAIT: init_done=1, go to IDLE.
- Handshake:
  - req_ready = 1 only in IDLE with init_done=1; it is registered.
  - Accept occurs on the cycle where req_valid && req_ready. req_rs and req_data are captured, and req_ready drops on the next cycle.
  - req_valid while not ready is ignored; upstream must hold it.
- Byte path:
  - HI_NIB: d = data[7:4].
  - GAP: T_NIBGAP cycles, e=0.
  - LO_NIB: d = data[3:0].
  - POST_WAIT: T_CLR if rs=0 and data is 0x01 or 0x02, otherwise T_CMD.
  - Then IDLE.
- Timing:
  - rs is held constant from accept to the end of POST_WAIT.
  - d=0 in IDLE.
  - Busy time after the accept edge = 2*(T_SETUP+T_PULSE+1) + T_NIBGAP + T_post cycles. req_ready is 1 in the following cycle.
- Single shared down-counter sized to clog2 of the largest parameter. It is loaded on each state entry; terminal count is 0.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined: full PWRON/INIT/CFG sequence as above.
- Undefined: FSM enters IDLE directly from reset. init_done=1 and req_ready=1 on the first cycle after rst deasserts. Used for fast simulation of the byte path; byte timing is unchanged.

Decomposition:
- Package lcd_pkg:
  - FSM state enum.
  - Init nibble/wait tables.
  - CFG byte constants 0x28, 0x06, 0x0C, 0x01.
  - Clear/home opcode constants.
- Sub-module lcd_nibble_strobe:
  - Inputs: start, nibble, rs.
  - Outputs: d, rs, e, done.
  - Implements the setup/pulse/hold timing, parameterized by T_SETUP and T_PULSE.
  - Reused by INIT_NIB, HI_NIB and LO_NIB.

Test Plan:
All scenarios use T_SETUP=2, T_PULSE=3, T_NIBGAP=4, T_CMD=5, T_CLR=9, T_PWRON=10, T_INIT1=8, T_INIT2=6.
1. Macro on, release rst → e pulses 4 times with d=3,3,3,2, then 8 byte-nibble pulses (2,8,0,6,0,C,0,1). init_done rises after the clear's 9-cycle wait. Each e-high lasts exactly 3 cycles.
2. After init, req_valid=1, req_rs=1, req_data=0x41 → d=4 then 1, rs=1 throughout, e high 3 cycles each. Busy 21 cycles; req_ready=1 in the 22nd.
3. Command 0x01 with rs=0 → post wait 9 cycles, total busy 25 cycles.
4. Back-to-back requests with req_valid held high → second byte accepted exactly on the first ready cycle, with no lost or duplicated byte.
5. Assert rst during LO_NIB with e=1 → e=0 next cycle, outputs at reset values, init sequence replays from PWRON.
6. Macro off → req_ready=1 one cycle after rst falls; byte 0x30 completes in 21 cycles; no init pulses observed.
